// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side fetch/data ports and shared-memory port of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the pipeline and memory around it.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_be;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          stall_mem;
  logic          stall_fetch;
  logic          bus_err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata, mem_ready,
    output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
           mem_be, stall_mem, stall_fetch, bus_err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata, mem_ready,
    input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
           mem_be, stall_mem, stall_fetch, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports; data always wins.
// Optional per-access timeout is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_t;

  state_t        state_r;
  state_t        next_state_s;

  logic          mem_req_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic [3:0]    mem_be_r;
  logic [DW-1:0] if_rdata_r;
  logic [DW-1:0] dm_rdata_r;
  logic          if_valid_r;
  logic          dm_valid_r;

  logic          access_s;
  logic          timeout_s;
  logic          done_s;
  logic          d_done_s;
  logic          i_done_s;
  logic          grant_eval_s;
  logic          dm_cand_s;
  logic          if_cand_s;
  logic          stall_mem_s;
  logic          stall_fetch_s;

  assign access_s = (state_r == D_ACC) || (state_r == I_ACC);

  // Completion and grant qualifiers; a requester finishing now cannot be re-granted this edge
  always_comb begin
    done_s       = access_s && (bus.mem_ready || timeout_s);
    d_done_s     = done_s && (state_r == D_ACC);
    i_done_s     = done_s && (state_r == I_ACC);
    grant_eval_s = (state_r == IDLE) || done_s;
    dm_cand_s    = bus.dm_req && !d_done_s;
    if_cand_s    = bus.if_req && !i_done_s;
  end

  // Next-state: arbitrate in IDLE or on completion, otherwise hold the access in flight
  always_comb begin
    next_state_s = state_r;
    if (grant_eval_s) begin
      if (dm_cand_s) begin
        next_state_s = D_ACC;
      end else if (if_cand_s) begin
        next_state_s = I_ACC;
      end else begin
        next_state_s = IDLE;
      end
    end else begin
      next_state_s = state_r;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Memory request launch, response capture and valid pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      mem_be_r    <= 4'h0;
      if_rdata_r  <= {DW{1'b0}};
      dm_rdata_r  <= {DW{1'b0}};
      if_valid_r  <= 1'b0;
      dm_valid_r  <= 1'b0;
    end else begin
      if_valid_r <= i_done_s;
      dm_valid_r <= d_done_s;

      if (i_done_s) begin
        if_rdata_r <= timeout_s ? {DW{1'b0}} : bus.mem_rdata;
      end

      // Stores leave dm_rdata untouched; a timed-out access returns zero
      if (d_done_s && timeout_s) begin
        dm_rdata_r <= {DW{1'b0}};
      end else if (d_done_s && !mem_we_r) begin
        dm_rdata_r <= bus.mem_rdata;
      end

      if (grant_eval_s) begin
        case (next_state_s)
          D_ACC: begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.dm_we;
            mem_addr_r  <= bus.dm_addr;
            mem_wdata_r <= bus.dm_wdata;
            mem_be_r    <= bus.dm_be;
          end
          I_ACC: begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= bus.if_addr;
            mem_be_r   <= 4'hF;
          end
          default: begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] wait_cnt_r;
  logic          bus_err_r;

  // Give up on the low-ready cycle that brings the wait count to the limit
  always_comb begin
    timeout_s = access_s && !bus.mem_ready && ((wait_cnt_r + CNT_ONE) == CNT_LIMIT);
  end

  // Wait counter: cleared whenever a new grant is evaluated, counts low-ready cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= {CW{1'b0}};
      bus_err_r  <= 1'b0;
    end else begin
      bus_err_r <= timeout_s;
      if (grant_eval_s) begin
        wait_cnt_r <= {CW{1'b0}};
      end else if (!bus.mem_ready) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  assign bus.bus_err = bus_err_r;
`else
  assign timeout_s   = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  // Data stall freezes F/D/E/M; fetch stall only matters when data is not stalling
  always_comb begin
    stall_mem_s   = bus.dm_req && !dm_valid_r;
    stall_fetch_s = bus.if_req && !if_valid_r && !stall_mem_s;
  end

  assign bus.mem_req     = mem_req_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wdata   = mem_wdata_r;
  assign bus.mem_be      = mem_be_r;
  assign bus.if_rdata    = if_rdata_r;
  assign bus.if_valid    = if_valid_r;
  assign bus.dm_rdata    = dm_rdata_r;
  assign bus.dm_valid    = dm_valid_r;
  assign bus.stall_mem   = stall_mem_s;
  assign bus.stall_fetch = stall_fetch_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; memory responses are driven by hand.
// The timeout scenario is compiled in only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h0;
    bus.dm_wdata  = 32'h0;
    bus.dm_be     = 4'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #2;
    total++; if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.bus_err} !== 5'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=00000", {bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.bus_err}); end
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_rdata, bus.dm_rdata} !== 132'h0) begin bad++; $display("FAIL rst_data got=%h want=0", {bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_rdata, bus.dm_rdata}); end
    tick();
    reset = 1'b0;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0040;
    tick();
    total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0000_0040}) begin bad++; $display("FAIL rst_pre_dacc got=%h want=%h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0000_0040}); end
    reset = 1'b1;
    #1;
    total++; if ({bus.mem_req, bus.mem_addr, bus.mem_be} !== 37'h0) begin bad++; $display("FAIL rst_async got=%h want=0", {bus.mem_req, bus.mem_addr, bus.mem_be}); end
    bus.mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    bus.dm_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    total++; if ({bus.mem_req, bus.if_valid, bus.dm_valid, bus.bus_err} !== 4'b0) begin bad++; $display("FAIL rst_no_pulse got=%b want=0000", {bus.mem_req, bus.if_valid, bus.dm_valid, bus.bus_err}); end
  endtask

  task automatic test_fetch_stream();
    logic [31:0] exp_ins;
    bus.if_req    = 1'b1;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_ins       = 32'hA5A5_0000 | 32'(k);
      bus.if_addr   = 32'(4 * k);
      bus.mem_rdata = exp_ins;
      tick();
      total++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'(4 * k)}) begin bad++; $display("FAIL fs_req[%0d] got=%h want=%h", k, {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b1, 1'b0, 4'hF, 32'(4 * k)}); end
      total++; if ({bus.if_valid, bus.stall_fetch} !== 2'b01) begin bad++; $display("FAIL fs_wait[%0d] got=%b want=01", k, {bus.if_valid, bus.stall_fetch}); end
      tick();
      total++; if ({bus.if_valid, bus.stall_fetch, bus.mem_req} !== 3'b100) begin bad++; $display("FAIL fs_valid[%0d] got=%b want=100", k, {bus.if_valid, bus.stall_fetch, bus.mem_req}); end
      total++; if (bus.if_rdata !== exp_ins) begin bad++; $display("FAIL fs_rdata[%0d] got=%h want=%h", k, bus.if_rdata, exp_ins); end
    end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    total++; if ({bus.mem_req, bus.if_valid} !== 2'b00) begin bad++; $display("FAIL fs_idle got=%b want=00", {bus.mem_req, bus.if_valid}); end
  endtask

  task automatic test_data_priority();
    int   stall_cnt;
    logic overlap;
    stall_cnt     = 0;
    overlap       = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0020;
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h0000_0100;
    bus.mem_ready = 1'b0;
    #1;
    if (bus.stall_mem) stall_cnt++;
    if (bus.stall_mem && bus.stall_fetch) overlap = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) begin
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h0000_0100}) begin bad++; $display("FAIL dp_grant got=%h want=%h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 32'h0000_0100}); end
      end
      bus.mem_ready = (c == 3);
      bus.mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      if (bus.stall_mem) stall_cnt++;
      if (bus.stall_mem && bus.stall_fetch) overlap = 1'b1;
    end
    tick();
    if (bus.stall_mem) stall_cnt++;
    total++; if ({bus.dm_valid, bus.if_valid} !== 2'b10) begin bad++; $display("FAIL dp_valid got=%b want=10", {bus.dm_valid, bus.if_valid}); end
    total++; if (bus.dm_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dp_rdata got=%h want=deadbeef", bus.dm_rdata); end
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.stall_fetch} !== {1'b1, 1'b0, 32'h0000_0020, 1'b1}) begin bad++; $display("FAIL dp_iacc got=%h want=%h", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.stall_fetch}, {1'b1, 1'b0, 32'h0000_0020, 1'b1}); end
    total++; if (stall_cnt !== 5) begin bad++; $display("FAIL dp_stall_cycles got=%0d want=5", stall_cnt); end
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL dp_overlap got=%b want=0", overlap); end
    bus.dm_req    = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h600D_F00D;
    tick();
    total++; if ({bus.if_valid, bus.dm_valid, bus.if_rdata} !== {1'b1, 1'b0, 32'h600D_F00D}) begin bad++; $display("FAIL dp_fetch got=%h want=%h", {bus.if_valid, bus.dm_valid, bus.if_rdata}, {1'b1, 1'b0, 32'h600D_F00D}); end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_store_during_fetch();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0040;
    bus.mem_ready = 1'b0;
    tick();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h0000_0200;
    bus.dm_be    = 4'b0011;
    bus.dm_wdata = 32'h1234_ABCD;
    #1;
    total++; if ({bus.stall_mem, bus.stall_fetch} !== 2'b10) begin bad++; $display("FAIL sd_stall got=%b want=10", {bus.stall_mem, bus.stall_fetch}); end
    tick();
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h0000_0040}) begin bad++; $display("FAIL sd_hold got=%h want=%h", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b1, 1'b0, 4'hF, 32'h0000_0040}); end
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BAD_CAFE;
    tick();
    total++; if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'h0BAD_CAFE}) begin bad++; $display("FAIL sd_fetch got=%h want=%h", {bus.if_valid, bus.if_rdata}, {1'b1, 32'h0BAD_CAFE}); end
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h1234_ABCD}) begin bad++; $display("FAIL sd_store got=%h want=%h", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h1234_ABCD}); end
    bus.if_req    = 1'b0;
    bus.mem_rdata = 32'h5555_5555;
    tick();
    total++; if ({bus.dm_valid, bus.dm_rdata, bus.mem_req} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin bad++; $display("FAIL sd_done got=%h want=%h", {bus.dm_valid, bus.dm_rdata, bus.mem_req}, {1'b1, 32'hDEAD_BEEF, 1'b0}); end
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h0000_0300;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0060;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h3030_3030;
    tick();
    total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0000_0300}) begin bad++; $display("FAIL bb_dgrant got=%h want=%h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0000_0300}); end
    tick();
    total++; if ({bus.dm_valid, bus.dm_rdata} !== {1'b1, 32'h3030_3030}) begin bad++; $display("FAIL bb_dvalid got=%h want=%h", {bus.dm_valid, bus.dm_rdata}, {1'b1, 32'h3030_3030}); end
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h0000_0060}) begin bad++; $display("FAIL bb_igrant got=%h want=%h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 32'h0000_0060}); end
    total++; if ({bus.stall_mem, bus.stall_fetch} !== 2'b01) begin bad++; $display("FAIL bb_stall got=%b want=01", {bus.stall_mem, bus.stall_fetch}); end
    bus.mem_ready = 1'b0;
    tick();
    total++; if ({bus.dm_valid, bus.if_valid, bus.mem_addr} !== {1'b0, 1'b0, 32'h0000_0060}) begin bad++; $display("FAIL bb_nodup got=%h want=%h", {bus.dm_valid, bus.if_valid, bus.mem_addr}, {1'b0, 1'b0, 32'h0000_0060}); end
    bus.dm_req    = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h6060_6060;
    tick();
    total++; if ({bus.if_valid, bus.dm_valid, bus.if_rdata} !== {1'b1, 1'b0, 32'h6060_6060}) begin bad++; $display("FAIL bb_ivalid got=%h want=%h", {bus.if_valid, bus.dm_valid, bus.if_rdata}, {1'b1, 1'b0, 32'h6060_6060}); end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_idle_ready_and_stale_pc();
    bus.mem_ready = 1'b1;
    tick();
    tick();
    total++; if ({bus.mem_req, bus.if_valid, bus.dm_valid} !== 3'b000) begin bad++; $display("FAIL ir_ignored got=%b want=000", {bus.mem_req, bus.if_valid, bus.dm_valid}); end
    bus.mem_ready = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0080;
    tick();
    bus.if_addr = 32'h0000_0090;
    tick();
    total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0000_0080}) begin bad++; $display("FAIL sp_latched got=%h want=%h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0000_0080}); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h8080_8080;
    tick();
    total++; if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'h8080_8080}) begin bad++; $display("FAIL sp_valid got=%h want=%h", {bus.if_valid, bus.if_rdata}, {1'b1, 32'h8080_8080}); end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h0000_0400;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    for (int c = 1; c < 4; c++) begin
      tick();
      total++; if ({bus.mem_req, bus.dm_valid, bus.bus_err} !== 3'b100) begin bad++; $display("FAIL to_wait[%0d] got=%b want=100", c, {bus.mem_req, bus.dm_valid, bus.bus_err}); end
    end
    tick();
    total++; if ({bus.dm_valid, bus.bus_err, bus.mem_req, bus.dm_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL to_fire got=%h want=%h", {bus.dm_valid, bus.bus_err, bus.mem_req, bus.dm_rdata}, {1'b1, 1'b1, 1'b0, 32'h0}); end
    bus.dm_req    = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0010;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1010_1010;
    tick();
    total++; if ({bus.bus_err, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h0000_0010}) begin bad++; $display("FAIL to_next got=%h want=%h", {bus.bus_err, bus.mem_req, bus.mem_addr}, {1'b0, 1'b1, 32'h0000_0010}); end
    tick();
    total++; if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'h1010_1010}) begin bad++; $display("FAIL to_recover got=%h want=%h", {bus.if_valid, bus.if_rdata}, {1'b1, 32'h1010_1010}); end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_stream();
    test_data_priority();
    test_store_during_fetch();
    test_back_to_back();
    test_idle_ready_and_stale_pc();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
